serial_adder_ctrl: RTL

//   Bit-serial WIDTH-bit adder built around a single one-bit full-adder cell.

---
 rtl/serial_adder_pkg.sv | 18 +
 rtl/serial_adder_ctrl_fa_bit_cell.sv | 13 +
 rtl/serial_adder_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared state encoding and sizing helper for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Ceiling log2; used to size the bit counter as clog2(WIDTH+1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa_bit_cell.sv
// One-bit full-adder cell driven by the serial adder controller.
module fa_bit_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ cin;
  assign co = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder controller around a single fa_bit_cell, LSB first.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = clog2(WIDTH + 1);

  state_t           state_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] sum_sr_q;
  logic [WIDTH-1:0] sum_sr_d;
  logic             carry_q;
  logic [CW-1:0]    count_q;
  logic             s_bit;
  logic             co_bit;
  logic             last_shift;
  logic [WIDTH:0]   sum_shift;
  logic             unused_sum_lsb;

  fa_bit_cell u_cell (
    .a  (a_sr_q[0]),
    .b  (b_sr_q[0]),
    .cin(carry_q),
    .s  (s_bit),
    .co (co_bit)
  );

  // New sum bit enters at the MSB; the oldest LSB position falls off the bottom.
  assign sum_shift      = {s_bit, sum_sr_q};
  assign sum_sr_d       = sum_shift[WIDTH:1];
  assign unused_sum_lsb = sum_shift[0];
  assign last_shift     = (count_q == CW'(WIDTH - 1));

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q;
  assign ovf = ovf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      count_q  <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_sr_q   <= a;
            b_sr_q   <= b;
            carry_q  <= cin;
            count_q  <= '0;
            sum_sr_q <= '0;
            busy_q   <= 1'b1;
            state_q  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          sum_sr_q <= sum_sr_d;
          a_sr_q   <= a_sr_q >> 1;
          b_sr_q   <= b_sr_q >> 1;
          carry_q  <= co_bit;
          count_q  <= count_q + 1'b1;
          if (last_shift) begin
            sum_q   <= sum_sr_d;
            cout_q  <= co_bit;
`ifdef SERIAL_ADDER_OVF_EN
            // carry_q is the carry into the MSB during the final bit.
            ovf_q   <= carry_q ^ co_bit;
`endif
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
